// File: rtl/cdb_writeback_if.sv
// Bundle of the three functional-unit result ports and the common data bus.
// The master side belongs to the producers of results and the consumers of
// the broadcast; the slave side belongs to the writeback stage.
interface cdb_writeback_if #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3
);
    logic              f0_valid;
    logic              f1_valid;
    logic              f3_valid;
    logic [TAG_W-1:0]  f0_tag;
    logic [TAG_W-1:0]  f1_tag;
    logic [TAG_W-1:0]  f3_tag;
    logic [DATA_W-1:0] f0_value;
    logic [DATA_W-1:0] f1_value;
    logic [DATA_W-1:0] f3_value;
    logic              f0_ready;
    logic              f1_ready;
    logic              f3_ready;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic [1:0]        cdb_src;
    logic              f0_release;
    logic              f1_release;
    logic              f3_release;
    logic [7:0]        cdb_count;

    modport master (
        output f0_valid, f1_valid, f3_valid,
        output f0_tag, f1_tag, f3_tag,
        output f0_value, f1_value, f3_value,
        input  f0_ready, f1_ready, f3_ready,
        input  cdb_valid, cdb_tag, cdb_value, cdb_src,
        input  f0_release, f1_release, f3_release,
        input  cdb_count
    );

    modport slave (
        input  f0_valid, f1_valid, f3_valid,
        input  f0_tag, f1_tag, f3_tag,
        input  f0_value, f1_value, f3_value,
        output f0_ready, f1_ready, f3_ready,
        output cdb_valid, cdb_tag, cdb_value, cdb_src,
        output f0_release, f1_release, f3_release,
        output cdb_count
    );
endinterface

// File: rtl/cdb_writeback.sv
// Common-data-bus writeback stage. Each functional unit (F0, F1, F3) owns a
// one-entry result buffer; a round-robin arbiter picks one full buffer per
// clock and broadcasts it on registered CDB outputs with a release strobe.
// Internal index 0/1/2 corresponds to F0/F1/F3 and equals the cdb_src code.
module cdb_writeback #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3
) (
    input  logic          clk,
    input  logic          rst,
    cdb_writeback_if.slave bus
);
    localparam int NSRC = 3;

    logic [NSRC-1:0]   in_valid;
    logic [TAG_W-1:0]  in_tag   [NSRC];
    logic [DATA_W-1:0] in_value [NSRC];

    logic [NSRC-1:0]   buf_full_reg;
    logic [TAG_W-1:0]  buf_tag_reg   [NSRC];
    logic [DATA_W-1:0] buf_value_reg [NSRC];

    logic [1:0]        rr_reg;
    logic [1:0]        rr_next;
    logic [1:0]        rr_eff;
    logic [1:0]        cand [NSRC];
    logic              grant_any;
    logic [1:0]        grant_idx;
    logic [NSRC-1:0]   grant;
    logic [NSRC-1:0]   ready;

    logic              cdb_valid_reg;
    logic [TAG_W-1:0]  cdb_tag_reg;
    logic [DATA_W-1:0] cdb_value_reg;
    logic [1:0]        cdb_src_reg;
    logic [NSRC-1:0]   release_reg;
    logic [7:0]        cdb_count_reg;

    assign in_valid    = {bus.f3_valid, bus.f1_valid, bus.f0_valid};
    assign in_tag[0]   = bus.f0_tag;
    assign in_tag[1]   = bus.f1_tag;
    assign in_tag[2]   = bus.f3_tag;
    assign in_value[0] = bus.f0_value;
    assign in_value[1] = bus.f1_value;
    assign in_value[2] = bus.f3_value;

    // The pointer value 3 cannot be reached; it is folded onto 0 for safety.
    assign rr_eff  = (rr_reg == 2'd3) ? 2'd0 : rr_reg;
    assign cand[0] = rr_eff;
    assign cand[1] = (rr_eff == 2'd2) ? 2'd0 : rr_eff + 2'd1;
    assign cand[2] = (rr_eff == 2'd0) ? 2'd2 : rr_eff - 2'd1;

    // Round-robin search: first full buffer in order rr, rr+1, rr+2 wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 2'd0;
        for (int k = 0; k < NSRC; k++) begin
            if (!grant_any && buf_full_reg[cand[k]]) begin
                grant_any = 1'b1;
                grant_idx = cand[k];
            end
        end
        grant   = grant_any ? (3'b001 << grant_idx) : 3'b000;
        rr_next = rr_reg;
        if (grant_any) begin
            rr_next = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_buf
            // A draining buffer may refill on the same edge, keeping one
            // result per cycle flowing from a single unit.
            assign ready[gi] = !rst && (!buf_full_reg[gi] || grant[gi]);

            // Per-unit result buffer: load on accept, clear when broadcast.
            always_ff @(posedge clk) begin
                if (rst) begin
                    buf_full_reg[gi]  <= 1'b0;
                    buf_tag_reg[gi]   <= '0;
                    buf_value_reg[gi] <= '0;
                end else if (in_valid[gi] && ready[gi]) begin
                    buf_full_reg[gi]  <= 1'b1;
                    buf_tag_reg[gi]   <= in_tag[gi];
                    buf_value_reg[gi] <= in_value[gi];
                end else if (grant[gi]) begin
                    buf_full_reg[gi]  <= 1'b0;
                end
            end
        end
    endgenerate

    // Arbiter pointer and registered CDB broadcast; payload holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_reg        <= 2'd0;
            cdb_valid_reg <= 1'b0;
            cdb_tag_reg   <= '0;
            cdb_value_reg <= '0;
            cdb_src_reg   <= 2'd0;
            release_reg   <= '0;
            cdb_count_reg <= 8'd0;
        end else begin
            rr_reg        <= rr_next;
            cdb_valid_reg <= grant_any;
            release_reg   <= grant;
            if (grant_any) begin
                cdb_tag_reg   <= buf_tag_reg[grant_idx];
                cdb_value_reg <= buf_value_reg[grant_idx];
                cdb_src_reg   <= grant_idx;
                cdb_count_reg <= cdb_count_reg + 8'd1;
            end
        end
    end

    assign bus.f0_ready   = ready[0];
    assign bus.f1_ready   = ready[1];
    assign bus.f3_ready   = ready[2];
    assign bus.cdb_valid  = cdb_valid_reg;
    assign bus.cdb_tag    = cdb_tag_reg;
    assign bus.cdb_value  = cdb_value_reg;
    assign bus.cdb_src    = cdb_src_reg;
    assign bus.f0_release = release_reg[0];
    assign bus.f1_release = release_reg[1];
    assign bus.f3_release = release_reg[2];
    assign bus.cdb_count  = cdb_count_reg;
endmodule
